div_iterative: RTL and testbench
================================

Name: div_iterative

Overview:
- Iterative 32-bit integer divider for the RISC-V M-extension DIV/DIVU/REM/REMU group.
- It is the inverse-operation companion of the team's multi-cycle multiplier and uses the same start/done handshake and func3 encoding.
- It sits beside the multiplier in the execute stage.
- It uses a radix-2 restoring algorithm: one quotient bit per cycle, fixed latency, and no early termination.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset.
- start  in  1  request; sampled only in IDLE.
- operA  in  XLEN  dividend.
- operB  in  XLEN  divisor.
- func3  in  3  op select on bits [1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; bit 2 ignored.
- result  out  XLEN  quotient for DIV/DIVU, remainder for REM/REMU.
- quotient_out  out  XLEN  signed-corrected quotient, always driven.
- remainder_out  out  XLEN  signed-corrected remainder, always driven.
- div_by_zero  out  1  divisor was zero.
- overflow  out  1  signed overflow case (DIV/REM with 0x80000000 / 0xFFFFFFFF).
- busy  out  1  high in every state except IDLE.
- done  out  1  result valid.

Behaviour:
- Reset: one clock, synchronous, active-high on rst.
  - Reset value of every output is 0, and state goes to IDLE.
  - Assertion mid-operation aborts the operation: on the next edge state is IDLE and done is 0.
- State machine: IDLE -> ABS_CALC -> DIVIDE -> SIGN_FIX -> DONE -> IDLE.
  - IDLE: operA, operB and func3[1:0] are registered every cycle. When start=1, go to ABS_CALC; func3 is latched, so later changes have no effect.
  - ABS_CALC:
    - Signed ops (func3[0]=0): take the two's-complement absolute value of each operand with a negative MSB.
    - Unsigned ops: operands pass unchanged.
    - Record neg_q = signA XOR signB (signed ops only) and neg_r = signA (signed ops only).
    - Clear the 33-bit partial remainder; load the quotient shift register with |A|; set the iteration counter to XLEN-1.
  - DIVIDE, one iteration per cycle:
    - Shift {rem,quo} left by 1.
    - trial = rem - |B| at 33 bits.
    - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise rem is restored and the LSB = 0.
    - The counter decrements; leave the state after the iteration where the counter is 0 (exactly XLEN cycles).
  - SIGN_FIX: compute final values and register all outputs.
    - quotient = neg_q ? -quo : quo.
    - remainder = neg_r ? -rem : rem.
    - Special cases override the above (see below).
  - DONE: done=1.
    - Stay while start=1; return to IDLE on the first cycle start=0.
    - Outputs hold stable until the next operation's SIGN_FIX; they are not cleared in IDLE.
- Latency: if start is sampled high in IDLE at edge T, done rises after edge T+35 (1 ABS + 32 DIVIDE + 1 SIGN_FIX + entry to DONE). Latency is identical for all operands, including special cases.
- start while busy in ABS_CALC/DIVIDE/SIGN_FIX: ignored.
- Divide by zero (B==0), all ops: quotient = 0xFFFFFFFF, remainder = A, div_by_zero=1, overflow=0.
- Signed overflow (func3[0]=0, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0, overflow=1.
- Flags: div_by_zero and overflow are registered in SIGN_FIX, are 0 for all other cases, and hold with the result.
- Invariant (non-special cases): A == quotient*B + remainder. The remainder sign equals the dividend sign for signed ops, or it is 0.
- Internal datapath widths: magnitude 32 bits, partial remainder 33 bits, counter 5 bits. Negation is two's complement truncated to XLEN.

Test Plan:
- DIV operA=0xFFFFFFF9 (-7), operB=2, start pulse -> done after 35 cycles.
  - result=0xFFFFFFFD (-3), remainder_out=0xFFFFFFFF (-1), flags 0.
  - Repeat with REM -> result=0xFFFFFFFF.
- DIVU operA=0xFFFFFFFF, operB=0x10 -> result=0x0FFFFFFF, remainder_out=0xF.
  - REMU on the same operands -> result=0xF.
- Divide by zero: DIV 5/0 -> result=0xFFFFFFFF, div_by_zero=1.
  - REM 5/0 -> result=5.
  - DIVU 0x80000000/0 -> result=0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> result=0x80000000, overflow=1.
  - REM on the same operands -> result=0.
  - DIVU on the same operands -> result=0, overflow=0.
- Handshake:
  - Hold start=1 for 50 cycles -> done stays 1 from cycle 35 until start drops, then IDLE and busy=0 the next cycle.
  - Change operA/func3 during DIVIDE -> result unaffected.
- Reset mid-op: assert rst for one cycle at DIVIDE iteration 10 -> next cycle state IDLE, busy=0, done=0, result=0.
  - A new DIV 100/7 then yields result=14, remainder_out=2.

Source files
------------

// File: rtl/div_iterative_if.sv
// ---------------------------------------------------------------------------
// div_iterative_if
//
// Bundles the request and response signals of the iterative divider.
//   master modport : issues start/operA/operB/func3, observes the results
//   slave modport  : the divider itself
// Signals:
//   start          request, sampled by the divider only while idle
//   operA / operB  dividend / divisor
//   func3          [1:0] selects DIV/DIVU/REM/REMU, bit 2 is don't-care
//   result         quotient (DIV/DIVU) or remainder (REM/REMU)
//   quotient_out   signed-corrected quotient
//   remainder_out  signed-corrected remainder
//   div_by_zero    divisor was zero
//   overflow       signed INT_MIN / -1 case
//   busy           divider is not idle
//   done           result valid
// ---------------------------------------------------------------------------
interface div_iterative_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] operA;
    logic [XLEN-1:0] operB;
    logic [2:0]      func3;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] quotient_out;
    logic [XLEN-1:0] remainder_out;
    logic            div_by_zero;
    logic            overflow;
    logic            busy;
    logic            done;

    modport master (
        output start, operA, operB, func3,
        input  result, quotient_out, remainder_out,
               div_by_zero, overflow, busy, done
    );

    modport slave (
        input  start, operA, operB, func3,
        output result, quotient_out, remainder_out,
               div_by_zero, overflow, busy, done
    );
endinterface

// File: rtl/div_iterative.sv
// ---------------------------------------------------------------------------
// div_iterative
//
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient bit per
// cycle, fixed latency regardless of operands (special cases included).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, aborts any operation in flight
//   bus  div_iterative_if.slave (request, results, flags, busy/done)
// Sequence: IDLE -> ABS_CALC -> DIVIDE (XLEN cycles) -> SIGN_FIX -> DONE.
// All outputs are registered; results hold until the next SIGN_FIX.
// ---------------------------------------------------------------------------
module div_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_iterative_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ABS_CALC,
        DIVIDE,
        SIGN_FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] mag_b_q, mag_b_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            is_dbz;
    logic            is_ovf;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic            func3_unused;
    logic            rem_top_unused;

    // func3[2] carries no meaning for the divide group.
    assign func3_unused = bus.func3[2];

    // After a restore the partial remainder is always below |B|, so its top
    // bit is never needed when shifting in the next dividend bit.
    assign rem_top_unused = rem_q[XLEN];

    // Operand conditioning and the single restoring-division step. Only
    // signed ops treat a set MSB as negative.
    always_comb begin
        is_signed = ~op_q[0];
        sign_a    = is_signed & a_q[XLEN-1];
        sign_b    = is_signed & b_q[XLEN-1];
        abs_a     = sign_a ? (~a_q + ONE) : a_q;
        abs_b     = sign_b ? (~b_q + ONE) : b_q;
        shifted   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial     = shifted - {1'b0, mag_b_q};
        is_dbz    = (b_q == '0);
        is_ovf    = is_signed && (a_q == INT_MIN) && (b_q == '1);
        quo_fix   = neg_quo_q ? (~quo_q + ONE) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];
    end

    // Next-state and next-output logic for the whole controller/datapath.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        mag_b_d     = mag_b_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                // Operands track the bus every idle cycle so the values
                // present on the start edge are the ones captured.
                a_d  = bus.operA;
                b_d  = bus.operB;
                op_d = bus.func3[1:0];
                if (bus.start) begin
                    state_d = ABS_CALC;
                end
            end
            ABS_CALC: begin
                mag_b_d   = abs_b;
                neg_quo_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                rem_d     = '0;
                quo_d     = abs_a;
                cnt_d     = CW'(XLEN - 1);
                state_d   = DIVIDE;
            end
            DIVIDE: begin
                // A negative trial (bit XLEN set) means the divisor did not
                // fit: keep the shifted remainder and shift in a 0.
                if (!trial[XLEN]) begin
                    rem_d = trial;
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = SIGN_FIX;
                end
            end
            SIGN_FIX: begin
                if (is_dbz) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                end else if (is_ovf) begin
                    quotient_d  = INT_MIN;
                    remainder_d = '0;
                end else begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                end
                if (is_dbz) begin
                    result_d = op_q[1] ? a_q : '1;
                end else if (is_ovf) begin
                    result_d = op_q[1] ? '0 : INT_MIN;
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end
                dbz_d   = is_dbz;
                ovf_d   = is_ovf && !is_dbz;
                state_d = DONE;
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        // done follows the DONE state by one registered stage.
        done_d = (state_q == DONE);
    end

    // All state and outputs are registered; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            mag_b_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            mag_b_q     <= mag_b_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.result        = result_q;
    assign bus.quotient_out  = quotient_q;
    assign bus.remainder_out = remainder_q;
    assign bus.div_by_zero   = dbz_q;
    assign bus.overflow      = ovf_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_div_iterative.sv
// ---------------------------------------------------------------------------
// tb_div_iterative
//
// Directed vectors with hand-computed answers for div_iterative. Each issued
// operation pushes its expected response into a queue; a monitor pops and
// compares whenever done rises, including the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_div_iterative;
    localparam int XLEN    = 32;
    localparam int LATENCY = 35;

    localparam logic [2:0] F_DIV  = 3'b000;
    localparam logic [2:0] F_DIVU = 3'b001;
    localparam logic [2:0] F_REM  = 3'b010;
    localparam logic [2:0] F_REMU = 3'b011;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dbz;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   start_cycle;
    int   done_events;
    int   checks;
    int   fails;
    exp_t sb[$];

    div_iterative_if #(.XLEN(XLEN)) bus ();

    div_iterative #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and cycle counter used for latency measurement.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1 && done_prev !== 1'b1) begin
                done_events++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput({e.name, ".result"}, bus.result, e.res);
                    checkOutput({e.name, ".quotient"}, bus.quotient_out, e.quo);
                    checkOutput({e.name, ".remainder"}, bus.remainder_out, e.rem);
                    checkOutput({e.name, ".div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                    checkOutput({e.name, ".overflow"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
                    checkOutput({e.name, ".latency"}, 32'(cyc - start_cycle), 32'(LATENCY));
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic pushExpect(input string name, input logic [31:0] res,
                              input logic [31:0] quo, input logic [31:0] rem,
                              input logic dbz, input logic ovf);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.quo  = quo;
        e.rem  = rem;
        e.dbz  = dbz;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    // Wait until the monitor has seen a new done and done has dropped again.
    task automatic waitForDone(input string name, input int ev0);
        int n;
        n = 0;
        while (!(done_events != ev0 && bus.done === 1'b0) && n < 120) begin
            @(negedge clk);
            n++;
        end
        if (n >= 120) begin
            checkOutput({name, ".timeout"}, 32'd1, 32'd0);
        end
    endtask

    // Issue one operation; start is held for 'hold' sampled edges.
    task automatic applyStimulus(input string name, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] res, input logic [31:0] quo,
                                 input logic [31:0] rem, input logic dbz,
                                 input logic ovf, input int hold);
        int  ev0;
        bit  seen;
        ev0 = done_events;
        pushExpect(name, res, quo, rem, dbz, ovf);
        @(negedge clk);
        bus.func3   = f3;
        bus.operA   = a;
        bus.operB   = b;
        bus.start   = 1'b1;
        start_cycle = cyc + 1;
        seen        = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (seen) begin
                checkOutput({name, ".done_held"}, {31'd0, bus.done}, 32'd1);
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (hold > 1) begin
            checkOutput({name, ".done_seen_while_held"}, {31'd0, seen}, 32'd1);
            @(negedge clk);
            checkOutput({name, ".busy_after_release"}, {31'd0, bus.busy}, 32'd0);
        end
        waitForDone(name, ev0);
    endtask

    initial begin
        int ev0;
        cyc         = 0;
        start_cycle = 0;
        done_events = 0;
        checks      = 0;
        fails       = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.operA   = '0;
        bus.operB   = '0;
        bus.func3   = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset.result", bus.result, 32'h0);
        checkOutput("reset.quotient", bus.quotient_out, 32'h0);
        checkOutput("reset.remainder", bus.remainder_out, 32'h0);
        checkOutput("reset.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset.done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset.flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed and unsigned basics.
        applyStimulus("div_m7_2",   F_DIV,  32'hFFFFFFF9, 32'd2,  32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        applyStimulus("rem_m7_2",   F_REM,  32'hFFFFFFF9, 32'd2,  32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        applyStimulus("divu_max16", F_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 1);
        applyStimulus("remu_max16", F_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 1);
        applyStimulus("div_7_m2",   F_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1);
        applyStimulus("rem_7_m2",   F_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1);
        applyStimulus("divu_100_7_f3b2", 3'b101, 32'd100, 32'd7, 32'd14, 32'd14, 32'd2, 1'b0, 1'b0, 1);

        // Divide by zero.
        applyStimulus("div_5_0",  F_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1);
        applyStimulus("rem_5_0",  F_REM,  32'd5, 32'd0, 32'd5,        32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1);
        applyStimulus("divu_min_0", F_DIVU, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1);

        // Signed overflow and its unsigned counterpart.
        applyStimulus("div_ovf",  F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1);
        applyStimulus("rem_ovf",  F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1);
        applyStimulus("divu_ovf", F_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1);

        // Start held for 50 cycles: done must stay high until release.
        applyStimulus("div_hold", F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 50);

        // Operand and op changes mid-operation must be ignored.
        ev0 = done_events;
        pushExpect("divu_change", 32'd100, 32'd100, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.func3   = F_DIVU;
        bus.operA   = 32'd1000;
        bus.operB   = 32'd10;
        bus.start   = 1'b1;
        start_cycle = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        bus.func3 = F_REM;
        bus.operA = 32'd3;
        bus.operB = 32'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitForDone("divu_change", ev0);

        // Reset at DIVIDE iteration 10 aborts the operation.
        @(negedge clk);
        bus.func3 = F_DIV;
        bus.operA = 32'd1000;
        bus.operB = 32'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort.done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort.result", bus.result, 32'h0);
        checkOutput("abort.quotient", bus.quotient_out, 32'h0);

        applyStimulus("div_100_7", F_DIV, 32'd100, 32'd7, 32'd14, 32'd14, 32'd2, 1'b0, 1'b0, 1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
